// File: rtl/uart_mem_bridge.sv
// Byte-stream command parser bridging a UART receiver/transmitter pair to a
// dual-port memory: single/burst writes on port A, ranged reads on port B.
module uart_mem_bridge #(
  parameter int         ADDR_WIDTH     = 16,
  parameter int         DATA_BYTES     = 4,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] ACK_BYTE       = 8'hA5,
  parameter logic [7:0] NAK_BYTE       = 8'h5A
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  input  logic                    tx_ready,
  output logic                    tx_valid,
  output logic [7:0]              tx_data,
  output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
  output logic [DATA_BYTES-1:0]   mem_we,
  output logic [8*DATA_BYTES-1:0] mem_wr_data,
  output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
  input  logic [8*DATA_BYTES-1:0] mem_rd_data,
  output logic                    busy
);

  localparam int AB    = (ADDR_WIDTH + 7) / 8;
  localparam int HDR_W = 16 * AB;
  localparam int DW    = 8 * DATA_BYTES;
  localparam int SHIFT = $clog2(DATA_BYTES);
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] OP_WRITE = 8'h0F;
  localparam logic [7:0] OP_BURST = 8'h3C;
  localparam logic [7:0] OP_READ  = 8'hFF;
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_BYTES);

  typedef enum logic [3:0] {
    IDLE, RX_HDR, RX_DATA, WRITE, RD_CHECK, RD_ISSUE, RD_WAIT, RD_SEND, SEND_RSP
  } state_t;

  state_t                state_reg;
  logic                  is_read_reg;
  logic                  is_burst_reg;
  logic [7:0]            byte_cnt_reg;
  logic [HDR_W-1:0]      hdr_reg;
  logic [HDR_W-1:0]      hdr_next;
  logic [DW-1:0]         data_reg;
  logic [DW-1:0]         data_next;
  logic [DW-1:0]         rd_word_reg;
  logic [DATA_BYTES-1:0] strobe_reg;
  logic [7:0]            words_left_reg;
  logic [ADDR_WIDTH-1:0] word_addr_reg;
  logic [ADDR_WIDTH-1:0] rd_left_reg;
  logic [TW-1:0]         timer_reg;

  logic [ADDR_WIDTH-1:0] lo_addr;
  logic [ADDR_WIDTH-1:0] hi_addr;
  logic [ADDR_WIDTH-1:0] range_diff;
  logic [7:0]            hdr_last;
  logic                  timed_out;
  logic                  is_opcode;

  // Incoming bytes land at the slot selected by byte_cnt_reg (little-endian).
  for (genvar gi = 0; gi < 2 * AB; gi++) begin : g_hdr
    assign hdr_next[8*gi +: 8] = (byte_cnt_reg == 8'(gi)) ? rx_data : hdr_reg[8*gi +: 8];
  end
  for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_data
    assign data_next[8*gi +: 8] = (byte_cnt_reg == 8'(gi)) ? rx_data : data_reg[8*gi +: 8];
  end

  assign lo_addr    = hdr_reg[ADDR_WIDTH-1:0];
  assign hi_addr    = hdr_reg[8*AB +: ADDR_WIDTH];
  assign range_diff = hi_addr - lo_addr;
  // Write headers end on the strobe/count byte, read headers on the last hi byte.
  assign hdr_last   = is_read_reg ? 8'(2*AB - 1) : 8'(AB);
  assign timed_out  = (timer_reg == TW'(TIMEOUT_CYCLES - 1));
  assign is_opcode  = (rx_data == OP_WRITE) || (rx_data == OP_BURST) || (rx_data == OP_READ);
  assign busy       = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      is_read_reg    <= 1'b0;
      is_burst_reg   <= 1'b0;
      byte_cnt_reg   <= '0;
      hdr_reg        <= '0;
      data_reg       <= '0;
      rd_word_reg    <= '0;
      strobe_reg     <= '0;
      words_left_reg <= '0;
      word_addr_reg  <= '0;
      rd_left_reg    <= '0;
      timer_reg      <= '0;
      tx_valid       <= 1'b0;
      tx_data        <= '0;
      mem_we         <= '0;
      mem_wr_addr    <= '0;
      mem_wr_data    <= '0;
      mem_rd_addr    <= '0;
    end else begin
      mem_we <= '0;
      case (state_reg)
        IDLE: begin
          timer_reg    <= '0;
          byte_cnt_reg <= '0;
          if (rx_valid && is_opcode) begin
            is_read_reg  <= (rx_data == OP_READ);
            is_burst_reg <= (rx_data == OP_BURST);
            state_reg    <= RX_HDR;
          end
        end
        RX_HDR: begin
          if (rx_valid) begin
            timer_reg <= '0;
            hdr_reg   <= hdr_next;
            if (byte_cnt_reg == hdr_last) begin
              byte_cnt_reg <= '0;
              if (is_read_reg) begin
                state_reg <= RD_CHECK;
              end else begin
                word_addr_reg  <= lo_addr;
                strobe_reg     <= rx_data[DATA_BYTES-1:0];
                words_left_reg <= is_burst_reg ? rx_data : 8'd0;
                state_reg      <= RX_DATA;
              end
            end else begin
              byte_cnt_reg <= byte_cnt_reg + 8'd1;
            end
          end else if (timed_out) begin
            state_reg <= IDLE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_valid) begin
            timer_reg <= '0;
            data_reg  <= data_next;
            if (byte_cnt_reg == 8'(DATA_BYTES - 1)) begin
              byte_cnt_reg <= '0;
              mem_we       <= is_burst_reg ? {DATA_BYTES{1'b1}} : strobe_reg;
              mem_wr_addr  <= word_addr_reg;
              mem_wr_data  <= data_next;
              state_reg    <= WRITE;
            end else begin
              byte_cnt_reg <= byte_cnt_reg + 8'd1;
            end
          end else if (timed_out) begin
            state_reg <= IDLE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        WRITE: begin
          timer_reg <= '0;
          if (words_left_reg != 8'd0) begin
            words_left_reg <= words_left_reg - 8'd1;
            word_addr_reg  <= word_addr_reg + STEP;
            state_reg      <= RX_DATA;
          end else begin
            tx_valid  <= 1'b1;
            tx_data   <= ACK_BYTE;
            state_reg <= SEND_RSP;
          end
        end
        RD_CHECK: begin
          if (hi_addr < lo_addr) begin
            tx_valid  <= 1'b1;
            tx_data   <= NAK_BYTE;
            state_reg <= SEND_RSP;
          end else begin
            // Count-based termination avoids wrap-around at the top of memory.
            rd_left_reg <= range_diff >> SHIFT;
            mem_rd_addr <= lo_addr;
            state_reg   <= RD_ISSUE;
          end
        end
        RD_ISSUE: state_reg <= RD_WAIT;
        RD_WAIT: begin
          tx_valid     <= 1'b1;
          tx_data      <= mem_rd_data[7:0];
          rd_word_reg  <= mem_rd_data >> 8;
          byte_cnt_reg <= '0;
          state_reg    <= RD_SEND;
        end
        RD_SEND: begin
          if (tx_ready) begin
            if (byte_cnt_reg == 8'(DATA_BYTES - 1)) begin
              tx_valid     <= 1'b0;
              byte_cnt_reg <= '0;
              if (rd_left_reg != '0) begin
                rd_left_reg <= rd_left_reg - 1'b1;
                mem_rd_addr <= mem_rd_addr + STEP;
                state_reg   <= RD_ISSUE;
              end else begin
                state_reg <= IDLE;
              end
            end else begin
              tx_data      <= rd_word_reg[7:0];
              rd_word_reg  <= rd_word_reg >> 8;
              byte_cnt_reg <= byte_cnt_reg + 8'd1;
            end
          end
        end
        SEND_RSP: begin
          if (tx_ready) begin
            tx_valid  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Self-checking bench for uart_mem_bridge: frame-level reference model,
// byte-addressed BRAM model, directed vectors plus randomized frames.
`timescale 1ns/1ps
module tb_uart_mem_bridge;
  localparam int AW = 16;
  localparam int DB = 4;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst, rx_valid, tx_ready, tx_valid, busy;
  logic [7:0]  rx_data, tx_data;
  logic [15:0] mem_wr_addr, mem_rd_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wr_data, mem_rd_data;

  int checks = 0;
  int errors = 0;
  int bp_mode = 0;
  int stab_viol = 0;
  bit stall_prev = 1'b0;
  logic [7:0] data_prev;

  bit [7:0]    ram [0:65535];
  bit [7:0]    model_mem [0:65535];
  logic [7:0]  frame[$];
  logic [51:0] exp_wr[$], act_wr[$];
  logic [7:0]  exp_tx[$], act_tx[$];

  uart_mem_bridge #(
    .ADDR_WIDTH(AW), .DATA_BYTES(DB), .TIMEOUT_CYCLES(TO),
    .ACK_BYTE(8'hA5), .NAK_BYTE(8'h5A)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .mem_wr_addr(mem_wr_addr), .mem_we(mem_we), .mem_wr_data(mem_wr_data),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [15:0] a);
    logic [15:0] a1, a2, a3;
    a1 = a + 16'd1; a2 = a + 16'd2; a3 = a + 16'd3;
    return {ram[a3], ram[a2], ram[a1], ram[a]};
  endfunction

  always @(posedge clk) mem_rd_data <= ram_word(mem_rd_addr);

  // Monitor sampled mid-cycle: records writes and TX handshakes, checks TX hold.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (mem_we != 4'h0) begin
        act_wr.push_back({mem_wr_addr, mem_we, mem_wr_data});
        for (int i = 0; i < 4; i++)
          if (mem_we[i]) ram[mem_wr_addr + 16'(i)] = mem_wr_data[8*i +: 8];
      end
      if (stall_prev && (tx_valid !== 1'b1 || tx_data !== data_prev)) stab_viol++;
      if (tx_valid && tx_ready) act_tx.push_back(tx_data);
      stall_prev = tx_valid && !tx_ready;
      data_prev  = tx_data;
    end
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        0: tx_ready = 1'b1;
        1: tx_ready = ~tx_ready;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Reference model: interprets one frame straight from the command rules.
  task automatic model_frame();
    int i, n;
    logic [7:0] op, stb;
    logic [15:0] a, lo, hi;
    logic [31:0] w;
    i = 0;
    while (i < frame.size() && !(frame[i] inside {8'h0F, 8'h3C, 8'hFF})) i++;
    if (i >= frame.size()) return;
    op = frame[i];
    a  = {frame[i+2], frame[i+1]};
    if (op == 8'h0F) begin
      stb = frame[i+3];
      w = {frame[i+7], frame[i+6], frame[i+5], frame[i+4]};
      exp_wr.push_back({a, stb[3:0], w});
      for (int b = 0; b < 4; b++) if (stb[b]) model_mem[16'(int'(a) + b)] = w[8*b +: 8];
      exp_tx.push_back(8'hA5);
    end else if (op == 8'h3C) begin
      n = int'(frame[i+3]) + 1;
      for (int k = 0; k < n; k++) begin
        w = {frame[i+7+4*k], frame[i+6+4*k], frame[i+5+4*k], frame[i+4+4*k]};
        exp_wr.push_back({16'(int'(a) + 4*k), 4'hF, w});
        for (int b = 0; b < 4; b++) model_mem[16'(int'(a) + 4*k + b)] = w[8*b +: 8];
      end
      exp_tx.push_back(8'hA5);
    end else begin
      lo = a;
      hi = {frame[i+4], frame[i+3]};
      if (hi < lo) exp_tx.push_back(8'h5A);
      else
        for (int k = 0; k <= (int'(hi) - int'(lo)) / 4; k++)
          for (int b = 0; b < 4; b++) exp_tx.push_back(model_mem[16'(int'(lo) + 4*k + b)]);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1; rx_valid = 1'b1; rx_data = b;
    @(posedge clk); #1; rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  task automatic wait_idle(output bit to);
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) begin to = 1'b0; break; end
    end
  endtask

  task automatic run_frame(output bit to);
    model_frame();
    foreach (frame[i]) begin
      send_byte(frame[i]);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wait_idle(to);
    $display("frame op=%02h len=%0d writes=%0d tx_bytes=%0d timeout=%0d",
             frame[0], frame.size(), act_wr.size(), act_tx.size(), to);
  endtask

  task automatic clear_q();
    exp_wr.delete(); act_wr.delete(); exp_tx.delete(); act_tx.delete();
  endtask

  task automatic rand_frame();
    int kind, n;
    logic [15:0] a, h;
    frame.delete();
    kind = $urandom_range(0, 3);
    a = 16'h0200 + 16'(4 * $urandom_range(0, 63));
    if (kind == 0) begin
      frame = '{8'h0F, a[7:0], a[15:8], 8'($urandom_range(0, 15))};
      repeat (4) frame.push_back(8'($urandom));
    end else if (kind == 1) begin
      n = $urandom_range(0, 3);
      frame = '{8'h3C, a[7:0], a[15:8], 8'(n)};
      repeat (4 * (n + 1)) frame.push_back(8'($urandom));
    end else if (kind == 2) begin
      h = a + 16'(4 * $urandom_range(0, 5) + $urandom_range(0, 3));
      frame = '{8'hFF, a[7:0], a[15:8], h[7:0], h[15:8]};
    end else begin
      h = a - 16'($urandom_range(1, 12));
      frame = '{8'hFF, a[7:0], a[15:8], h[7:0], h[15:8]};
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({tx_valid, tx_data, mem_we, mem_wr_addr, mem_wr_data, mem_rd_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got tv=%b td=%h we=%h wa=%h wd=%h ra=%h want all 0",
               tx_valid, tx_data, mem_we, mem_wr_addr, mem_wr_data, mem_rd_addr);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    $display("reset done");
  endtask

  task automatic test_single_write();
    bit to;
    clear_q(); bp_mode = 0;
    frame = '{8'h0F, 8'h10, 8'h00, 8'h0F, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_frame(to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL single_idle1: busy stuck, got timeout=%0d want 0", to); end
    frame = '{8'h42, 8'h0F, 8'h20, 8'h00, 8'h03, 8'h44, 8'h33, 8'h22, 8'h11};
    run_frame(to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL single_idle2: busy stuck, got timeout=%0d want 0", to); end
    checks++;
    if (act_wr.size() != exp_wr.size()) begin
      errors++; $display("FAIL single_wr_count: got %0d want %0d", act_wr.size(), exp_wr.size());
    end else foreach (exp_wr[i]) begin
      checks++;
      if (act_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL single_wr[%0d]: got %h want %h", i, act_wr[i], exp_wr[i]); end
    end
    checks++;
    if (act_tx.size() != exp_tx.size()) begin
      errors++; $display("FAIL single_tx_count: got %0d want %0d", act_tx.size(), exp_tx.size());
    end else foreach (exp_tx[i]) begin
      checks++;
      if (act_tx[i] !== exp_tx[i]) begin errors++; $display("FAIL single_tx[%0d]: got %h want %h", i, act_tx[i], exp_tx[i]); end
    end
  endtask

  task automatic test_burst();
    bit to;
    clear_q(); bp_mode = 0;
    frame = '{8'h3C, 8'h00, 8'h01, 8'h01, 8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
    run_frame(to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL burst_idle1: got timeout=%0d want 0", to); end
    frame = '{8'h3C, 8'h40, 8'h03, 8'h04};
    repeat (20) frame.push_back(8'($urandom));
    run_frame(to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL burst_idle2: got timeout=%0d want 0", to); end
    checks++;
    if (act_wr.size() != exp_wr.size()) begin
      errors++; $display("FAIL burst_wr_count: got %0d want %0d", act_wr.size(), exp_wr.size());
    end else foreach (exp_wr[i]) begin
      checks++;
      if (act_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL burst_wr[%0d]: got %h want %h", i, act_wr[i], exp_wr[i]); end
    end
    checks++;
    if (act_tx.size() != exp_tx.size()) begin
      errors++; $display("FAIL burst_tx_count: got %0d want %0d", act_tx.size(), exp_tx.size());
    end else foreach (exp_tx[i]) begin
      checks++;
      if (act_tx[i] !== exp_tx[i]) begin errors++; $display("FAIL burst_tx[%0d]: got %h want %h", i, act_tx[i], exp_tx[i]); end
    end
  endtask

  task automatic test_read_backpressure();
    bit to;
    clear_q(); bp_mode = 1; stab_viol = 0;
    frame = '{8'hFF, 8'h00, 8'h01, 8'h04, 8'h01};
    run_frame(to);
    bp_mode = 2;
    frame = '{8'hFF, 8'h40, 8'h03, 8'h4E, 8'h03};
    run_frame(to);
    bp_mode = 0;
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL read_idle: got timeout=%0d want 0", to); end
    checks++;
    if (stab_viol !== 0) begin errors++; $display("FAIL read_tx_hold: got %0d violations want 0", stab_viol); end
    checks++;
    if (act_tx.size() != exp_tx.size()) begin
      errors++; $display("FAIL read_tx_count: got %0d want %0d", act_tx.size(), exp_tx.size());
    end else foreach (exp_tx[i]) begin
      checks++;
      if (act_tx[i] !== exp_tx[i]) begin errors++; $display("FAIL read_tx[%0d]: got %h want %h", i, act_tx[i], exp_tx[i]); end
    end
  endtask

  task automatic test_reset_mid_read();
    bit to;
    clear_q(); bp_mode = 0;
    frame = '{8'hFF, 8'h00, 8'h00, 8'hFC, 8'h00};
    foreach (frame[i]) send_byte(frame[i]);
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (act_tx.size() >= 6) begin to = 1'b0; break; end
    end
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL midread_stream: got %0d bytes want >=6", act_tx.size()); end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({tx_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL midread_reset: got tx_valid=%b busy=%b want 0 0", tx_valid, busy);
    end
    rst = 1'b0;
    $display("reset during read after %0d bytes", act_tx.size());
  endtask

  task automatic test_nak_top();
    bit to;
    clear_q(); bp_mode = 0;
    frame = '{8'hFF, 8'h08, 8'h00, 8'h04, 8'h00};
    run_frame(to);
    checks++;
    if (mem_rd_addr !== 16'h0000) begin errors++; $display("FAIL nak_rd_addr: got %h want 0000", mem_rd_addr); end
    frame = '{8'h0F, 8'hFC, 8'hFF, 8'h0F, 8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(to);
    frame = '{8'hFF, 8'hFC, 8'hFF, 8'hFC, 8'hFF};
    run_frame(to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL top_idle: got timeout=%0d want 0", to); end
    checks++;
    if (mem_rd_addr !== 16'hFFFC) begin errors++; $display("FAIL top_rd_addr: got %h want fffc", mem_rd_addr); end
    checks++;
    if (act_tx.size() != exp_tx.size()) begin
      errors++; $display("FAIL nak_top_tx_count: got %0d want %0d", act_tx.size(), exp_tx.size());
    end else foreach (exp_tx[i]) begin
      checks++;
      if (act_tx[i] !== exp_tx[i]) begin errors++; $display("FAIL nak_top_tx[%0d]: got %h want %h", i, act_tx[i], exp_tx[i]); end
    end
  endtask

  task automatic test_timeout();
    bit to;
    clear_q(); bp_mode = 0;
    send_byte(8'h0F); send_byte(8'h10); send_byte(8'h00);
    repeat (TO) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL timeout_early: got busy=%b want 1", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL timeout_expire: got busy=%b want 0", busy); end
    $display("timeout frame discarded");
    frame = '{8'h0F, 8'h10, 8'h00, 8'h0F};
    repeat (4) frame.push_back(8'($urandom));
    run_frame(to);
    checks++;
    if (act_wr.size() != exp_wr.size()) begin
      errors++; $display("FAIL timeout_wr_count: got %0d want %0d", act_wr.size(), exp_wr.size());
    end else foreach (exp_wr[i]) begin
      checks++;
      if (act_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL timeout_wr[%0d]: got %h want %h", i, act_wr[i], exp_wr[i]); end
    end
    checks++;
    if (act_tx.size() != exp_tx.size()) begin
      errors++; $display("FAIL timeout_tx_count: got %0d want %0d", act_tx.size(), exp_tx.size());
    end else foreach (exp_tx[i]) begin
      checks++;
      if (act_tx[i] !== exp_tx[i]) begin errors++; $display("FAIL timeout_tx[%0d]: got %h want %h", i, act_tx[i], exp_tx[i]); end
    end
  endtask

  task automatic test_random();
    bit to;
    int stuck = 0;
    clear_q(); bp_mode = 2; stab_viol = 0;
    for (int t = 0; t < 40; t++) begin
      rand_frame();
      run_frame(to);
      if (to) stuck++;
    end
    bp_mode = 0;
    checks++;
    if (stuck !== 0) begin errors++; $display("FAIL random_idle: got %0d stuck frames want 0", stuck); end
    checks++;
    if (stab_viol !== 0) begin errors++; $display("FAIL random_tx_hold: got %0d violations want 0", stab_viol); end
    checks++;
    if (act_wr.size() != exp_wr.size()) begin
      errors++; $display("FAIL random_wr_count: got %0d want %0d", act_wr.size(), exp_wr.size());
    end else foreach (exp_wr[i]) begin
      checks++;
      if (act_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL random_wr[%0d]: got %h want %h", i, act_wr[i], exp_wr[i]); end
    end
    checks++;
    if (act_tx.size() != exp_tx.size()) begin
      errors++; $display("FAIL random_tx_count: got %0d want %0d", act_tx.size(), exp_tx.size());
    end else foreach (exp_tx[i]) begin
      checks++;
      if (act_tx[i] !== exp_tx[i]) begin errors++; $display("FAIL random_tx[%0d]: got %h want %h", i, act_tx[i], exp_tx[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst();
    test_read_backpressure();
    test_reset_mid_read();
    test_nak_top();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
